// File: rtl/calc_entry_sequencer_pkg.sv
// Shared definitions for the calculator entry side and its arithmetic core.
// Contents:
//   - Opcode values that appear on the op bus.
//   - State encoding of the entry sequencer.
//   - Bit positions of the one-hot state LED vector.
//   - Helper that decodes a state into its LED vector.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [2:0] ST_GET_A  = 3'd0;
   localparam logic [2:0] ST_GET_B  = 3'd1;
   localparam logic [2:0] ST_GET_OP = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_SHOW   = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

   typedef enum logic [2:0] {
      S_GET_A  = ST_GET_A,
      S_GET_B  = ST_GET_B,
      S_GET_OP = ST_GET_OP,
      S_RUN    = ST_RUN,
      S_SHOW   = ST_SHOW,
      S_ERR    = ST_ERR
   } state_t;

   localparam int LED_W      = 6;
   localparam int LED_GET_A  = 0;
   localparam int LED_GET_B  = 1;
   localparam int LED_GET_OP = 2;
   localparam int LED_RUN    = 3;
   localparam int LED_SHOW   = 4;
   localparam int LED_ERR    = 5;

   // Unused encodings light GET_A, which is where the FSM recovers to.
   function automatic logic [LED_W-1:0] state_to_leds(state_t s);
      logic [LED_W-1:0] l;
      l = '0;
      case (s)
         S_GET_A:  l[LED_GET_A]  = 1'b1;
         S_GET_B:  l[LED_GET_B]  = 1'b1;
         S_GET_OP: l[LED_GET_OP] = 1'b1;
         S_RUN:    l[LED_RUN]    = 1'b1;
         S_SHOW:   l[LED_SHOW]   = 1'b1;
         S_ERR:    l[LED_ERR]    = 1'b1;
         default:  l[LED_GET_A]  = 1'b1;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/calc_entry_sequencer_if.sv
// Handshake between the entry sequencer and the arithmetic core.
// Signals:
//   a, b   - captured operands
//   op     - captured opcode
//   start  - one-cycle pulse, operands valid
//   done   - level from core, result valid
//   ack    - one-cycle pulse, result consumed
// Modports:
//   master - sequencer side
//   slave  - core side
interface calc_entry_sequencer_if;
   logic [15:0] a;
   logic [15:0] b;
   logic [1:0]  op;
   logic        start;
   logic        done;
   logic        ack;

   modport master (output a, b, op, start, ack, input done);
   modport slave  (input a, b, op, start, ack, output done);
endinterface

// File: rtl/calc_entry_sequencer_btn_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and
// rising-edge press pulse.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   raw   - asynchronous button level
//   press - one-cycle pulse on the debounced 0->1 transition
// A level change is accepted after DEBOUNCE_CYCLES consecutive cycles of
// disagreement between the synchronized and debounced levels, giving a
// raw-to-press latency of 2 + DEBOUNCE_CYCLES cycles.
module btn_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync2;
               cnt   <= '0;
               // Only the release->press direction produces a pulse.
               press <= sync2;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: debounces Confirm/Cancel, captures operand A,
// operand B and the opcode from the switches, starts the arithmetic core,
// waits for its result and acknowledges it once the user has seen it.
// Divide-by-zero is trapped here so the core is never started with it.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   btn_confirm  - raw Confirm button
//   btn_cancel   - raw Cancel button
//   sw           - 16 switch inputs
//   core         - handshake to the arithmetic core (master side)
//   err          - high while in ERR
//   state_leds   - one-hot state {ERR, SHOW, RUN, GET_OP, GET_B, GET_A}
//
// state  | meaning
// GET_A  | waiting for operand A on Confirm, Cancel clears A
// GET_B  | waiting for operand B on Confirm, Cancel back to GET_A
// GET_OP | waiting for opcode on Confirm, Cancel back to GET_B
// RUN    | core started, waiting for done, buttons ignored
// SHOW   | result shown, any press acks the core
// ERR    | divide-by-zero trapped, any press returns to GET_A
module calc_entry_sequencer
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  btn_confirm,
   input  logic                  btn_cancel,
   input  logic [15:0]           sw,
   calc_entry_sequencer_if.master core,
   output logic                  err,
   output logic [LED_W-1:0]      state_leds
);

   logic        c_press;
   logic        x_press;
   state_t      state;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [1:0]  op_q;
   logic        start_q;
   logic        ack_q;
   logic        err_q;

   btn_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_confirm (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_confirm),
      .press (c_press)
   );

   btn_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_cancel (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_cancel),
      .press (x_press)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_GET_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         start_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         ack_q   <= 1'b0;
         case (state)
            // In the entry states Cancel takes priority over a coincident Confirm.
            S_GET_A: begin
               if (x_press) begin
                  a_q <= '0;
               end else if (c_press) begin
                  a_q   <= sw;
                  state <= S_GET_B;
               end
            end
            S_GET_B: begin
               if (x_press) begin
                  state <= S_GET_A;
               end else if (c_press) begin
                  b_q   <= sw;
                  state <= S_GET_OP;
               end
            end
            S_GET_OP: begin
               if (x_press) begin
                  state <= S_GET_B;
               end else if (c_press) begin
                  if (sw[1:0] == OP_DIV && b_q == '0) begin
                     op_q  <= OP_DIV;
                     err_q <= 1'b1;
                     state <= S_ERR;
                  end else begin
                     op_q    <= sw[1:0];
                     start_q <= 1'b1;
                     state   <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (core.done) begin
                  state <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (c_press || x_press) begin
                  ack_q <= 1'b1;
                  state <= S_GET_A;
               end
            end
            S_ERR: begin
               if (c_press || x_press) begin
                  err_q <= 1'b0;
                  state <= S_GET_A;
               end
            end
            default: begin
               err_q <= 1'b0;
               state <= S_GET_A;
            end
         endcase
      end
   end

   assign core.a     = a_q;
   assign core.b     = b_q;
   assign core.op    = op_q;
   assign core.start = start_q;
   assign core.ack   = ack_q;
   assign err        = err_q;

   always_comb begin
      state_leds = state_to_leds(state);
   end

endmodule

// File: doc/calc_entry_sequencer.md
Name: calc_entry_sequencer

Overview:
- Input side of the simple calculator. It synchronizes and debounces the Confirm and Cancel pushbuttons, then captures operand A, operand B and the opcode from the 16 switches in sequence.
- It issues a one-cycle Start to the arithmetic core and waits for Done. After the user acknowledges the result, it returns Ack to the core.
- It flags divide-by-zero before issuing, so the core never sees it.
- The state vector is exported one-hot for the LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  in  1  system clock (100 MHz board clock).
- Reset  in  1  synchronous, active-high reset.
- BtnConfirm  in  1  raw Confirm pushbutton, asynchronous.
- BtnCancel  in  1  raw Cancel pushbutton, asynchronous.
- Input  in  16  switch bus {Sw15..Sw0}.
- Done  in  1  level from the core, high while a result is valid.
- A  out  16  captured operand A.
- B  out  16  captured operand B.
- Op  out  2  captured opcode: 00 add, 01 sub, 10 mul, 11 div.
- Start  out  1  one-cycle pulse; operands are valid and stable.
- Ack  out  1  one-cycle pulse; the user has consumed the result.
- Err  out  1  high in the ERR state.
- StateLeds  out  6  one-hot {QErr, QShow, QRun, QGetOp, QGetB, QGetA}.

Behaviour:
- The clock is one domain and Reset is synchronous active-high.
- Reset values:
  - State is GET_A.
  - A=0, B=0, Op=0.
  - Start=0, Ack=0, Err=0.
  - StateLeds=6'b000001.
  - All synchronizer flops and debounce counters are 0, and debounced levels are 0.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Counter increments while the synchronized level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
- A press is a single-cycle pulse on the debounced 0->1 transition.
- Latency from a stable raw press to the press pulse is exactly 2 + DEBOUNCE_CYCLES cycles.
- A bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- States and transitions (CPress/XPress = Confirm/Cancel press pulses):
  - GET_A:
    - CPress: A<=Input, go to GET_B.
    - XPress: A<=0.
  - GET_B:
    - CPress: B<=Input, go to GET_OP.
    - XPress: go to GET_A.
  - GET_OP:
    - CPress with Input[1:0]==11 and B==0: Op<=11, go to ERR.
    - Other CPress: Op<=Input[1:0], Start=1 for the next cycle only, go to RUN.
    - XPress: go to GET_B.
  - RUN:
    - Wait for Done=1, then go to SHOW.
    - Both buttons are ignored.
    - Done already high on entry is accepted on the first RUN cycle.
  - SHOW:
    - CPress: Ack=1 for one cycle, go to GET_A.
    - XPress behaves the same as CPress.
  - ERR:
    - Err=1.
    - Any press returns to GET_A. Ack is not pulsed, because the core was never started.
- Simultaneous CPress and XPress in the same cycle: Cancel wins in GET_A, GET_B and GET_OP. In SHOW and ERR both are treated as one press.
- Start and Ack are registered outputs. Start is high in the cycle after the CPress, coincident with the first RUN cycle.
- A, B and Op are held stable from Start until the next capture. The core may sample them at any time in RUN or SHOW.
- Reset mid-operation, including RUN, immediately returns to GET_A. No Ack is issued; the core must be reset by the same Reset.
- StateLeds are decoded directly from the state register and are always exactly one-hot.

Decomposition:
- Shared package calc_pkg holds:
  - the opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the state encoding localparams;
  - the StateLeds bit positions, shared with the core and the top.
- One sub-module, btn_debouncer: synchronizer, counter and rising-edge pulse, parameterized by DEBOUNCE_CYCLES and CNT_W. It is instantiated twice.
- The FSM and capture registers live in calc_entry_sequencer.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset sequence -> StateLeds=000001, A=B=0, Op=0, Start=Ack=Err=0.
- Raw Confirm bounce 1-0-1-0 at 1-cycle spacing, then 0 -> no press pulse and state stays GET_A. A clean press held 10 cycles -> pulse exactly 6 cycles after the rise.
- Add flow:
  - Input=0x0012, CPress -> A=0x0012, GET_B.
  - Input=0x0034, CPress -> B=0x0034.
  - Input=0x0000, CPress -> one-cycle Start, Op=00, RUN.
  - Core raises Done 5 cycles later -> SHOW.
  - CPress -> one-cycle Ack, GET_A.
- Divide by zero: A=0x0009, B=0x0000, Op Input=0x0003, CPress -> ERR, Err=1, Start never asserted. Then XPress -> GET_A, Err=0, no Ack.
- Cancel: in GET_OP, XPress -> GET_B with B unchanged. Then simultaneous CPress and XPress -> GET_A (Cancel wins). In RUN, XPress is ignored.
- Reset asserted 2 cycles into RUN -> next cycle GET_A, A=B=0, no Ack.
